atax_run_sequencer: RTL and testbench
=====================================

# atax_run_sequencer

Run controller for the synthesized atax kernel inside the board wrapper. It issues a fixed number of kernel runs and collects each run's y_out stream into a small FIFO. It serializes every 32-bit result word onto the 4-bit `data_out`/`data_valid` pins and drives `probe_out` as the pass/fail indicator. It sits between the kernel's ap-handshake/y_out ports and the wrapper's external pins.

## Interface
- `DATA_W`, 32, y_out word width (multiple of `NIB_W`)
- `NIB_W`, 4, serial output width
- `N_OUT`, 16, y_out words expected per run
- `NUM_RUNS`, 4, kernel runs per session
- `FIFO_DEPTH`, 8, result FIFO depth (power of 2)

- `ap_clk`  in  1  single clock
- `ap_rst_n`  in  1  asynchronous, active-low reset
- `kern_start`  out  1  kernel ap_start
- `kern_ready`  in  1  kernel ap_ready; accepts start
- `kern_done`  in  1  kernel ap_done, 1-cycle pulse
- `y_out_write`  in  1  kernel result write strobe
- `y_out_din`  in  DATA_W  kernel result word
- `y_out_full_n`  out  1  FIFO not full
- `data_out`  out  NIB_W  serialized nibble
- `data_valid`  out  1  `data_out` valid this cycle
- `probe_out`  out  1  1 = session finished with no error

## Operation
- FSM states: IDLE, START, WAIT, DRAIN, FINISH.
  - IDLE: one cycle after reset release, then go to START.
  - START: `kern_start`=1. When `kern_ready`=1 is sampled, go to WAIT.
  - WAIT: on `kern_done`, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and the serializer is idle. At exit, error if `word_cnt` != `N_OUT`. Then clear `word_cnt` and increment `run_cnt`. Go to FINISH if `run_cnt` reaches `NUM_RUNS`, else go to START.
  - FINISH: terminal state until reset.
- Write acceptance:
  - A write is accepted only when `y_out_write`=1 and `y_out_full_n`=1, in any state except IDLE.
  - Each accepted write increments `word_cnt`. The counter saturates at 2^clog2(`N_OUT`+1)-1.
- Overflow: a write while full is dropped and sets a sticky error flag.
- Early or late data:
  - A write in IDLE or FINISH is dropped and sets error.
  - Extra words beyond `N_OUT` are still forwarded but set error at DRAIN exit.
- Serializer:
  - Loads the FIFO head when idle or on its last nibble, if the FIFO is non-empty.
  - Emits `DATA_W/NIB_W` nibbles LSB-first, one per cycle, with `data_valid`=1.
  - Runs concurrently with the kernel.
- `probe_out` = 1 only in FINISH with the error flag clear; otherwise 0.
- `y_out_full_n` is derived from the registered FIFO occupancy (no full-cycle bypass). On a simultaneous push and pop when not full, both happen and occupancy is unchanged.

## Timing
- Reset values, held while `ap_rst_n`=0:
  - `kern_start`=0, `data_out`=0, `data_valid`=0, `probe_out`=0, `y_out_full_n`=0.
  - FIFO emptied, all counters and the error flag cleared, FSM in IDLE.
- `y_out_full_n` becomes 1 on the first edge after reset release.
- Reset mid-run: outputs drop immediately, without waiting for an edge. FIFO contents and the nibble in flight are discarded.
- `kern_start` is asserted on the edge after IDLE and held until the edge that samples `kern_ready`=1. It is 0 from the next cycle.
- Latency: for a word accepted at edge E, nibble 0 is on `data_out` with `data_valid`=1 in the cycle after edge E+2. Nibble k appears in the cycle after E+2+k.
- Back-to-back words produce continuous `data_valid`, with no gap between the last nibble of one word and nibble 0 of the next. Throughput is 1 word per 8 cycles at defaults.
- `kern_done` is accepted in WAIT only.
  - A `kern_done` in any other state is ignored and sets error.
  - A `kern_done` in the same cycle as the last write is legal: the write is counted.
- DRAIN exit takes at least 1 cycle after the last nibble. The START of the next run occurs no earlier than the cycle after `data_valid` falls.
- Error flag is sticky until reset.

## Test plan
- Nominal, defaults: 4 runs. In each run, the kernel asserts ready 3 cycles after start, writes 16 words 0x000000A0+i one per cycle, then pulses done. Required: 64×8 nibbles in order (0x000000A0 gives 0,A,0,0,0,0,0,0), `kern_start` exactly 4 times, `probe_out`=1 in FINISH.
- Backpressure: kernel writes 16 words in consecutive cycles; FIFO fills at 8. Required: `y_out_full_n`=0 while occupancy is 8, no lost word, `probe_out`=1.
- Forced overflow: one write with `y_out_full_n`=0. Required: word absent from output, `probe_out` stays 0 in FINISH.
- Short run: run 2 writes 15 words then done. Required: 15×8 nibbles for that run, next run still starts, final `probe_out`=0.
- Latency check: single write of 0x12345678 at edge E. Required: nibbles 8,7,6,5,4,3,2,1 on cycles E+3..E+10, `data_valid` high for exactly those 8 cycles.
- Reset mid-serialization: assert `ap_rst_n`=0 during nibble 3 of a word. Required: `data_valid`/`data_out`/`kern_start` go 0 immediately, and after release the sequence restarts from run 0 with an empty FIFO.

Source files
------------

// File: rtl/atax_run_sequencer.sv
// Run controller for the atax kernel: issues NUM_RUNS kernel runs, buffers y_out
// words in a small FIFO and streams them LSB-nibble-first onto the serial pins.
module atax_run_sequencer #(
  parameter int DATA_W     = 32,
  parameter int NIB_W      = 4,
  parameter int N_OUT      = 16,
  parameter int NUM_RUNS   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  output logic              kern_start,
  input  logic              kern_ready,
  input  logic              kern_done,
  input  logic              y_out_write,
  input  logic [DATA_W-1:0] y_out_din,
  output logic              y_out_full_n,
  output logic [NIB_W-1:0]  data_out,
  output logic              data_valid,
  output logic              probe_out
);

  localparam int NIBS  = DATA_W / NIB_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int WC_W  = $clog2(N_OUT + 1);
  localparam int RC_W  = $clog2(NUM_RUNS + 1);
  localparam int NC_W  = (NIBS > 1) ? $clog2(NIBS) : 1;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [WC_W-1:0]  WC_EXP   = WC_W'(N_OUT);
  localparam logic [WC_W-1:0]  WC_MAX   = {WC_W{1'b1}};
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(NUM_RUNS - 1);
  localparam logic [NC_W-1:0]  NIB_LAST = NC_W'(NIBS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e             state_q;
  logic               kern_start_q;
  logic               full_n_q;
  logic               probe_q;
  logic               err_q;
  logic [WC_W-1:0]    word_cnt_q;
  logic [RC_W-1:0]    run_cnt_q;

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_d;

  logic [DATA_W-1:0]  sh_q;
  logic [NC_W-1:0]    nib_cnt_q;
  logic               busy_q;
  logic [NIB_W-1:0]   data_out_q;
  logic               data_valid_q;

  logic wr_allowed, push, drop, pop, ser_last, ser_idle;
  logic drain_exit, last_run, done_err, cnt_err, err_set;

  // Handshake qualification, FIFO occupancy update and error sources
  always_comb begin
    wr_allowed = (state_q != S_IDLE) && (state_q != S_FINISH);
    push       = y_out_write && full_n_q && wr_allowed;
    drop       = y_out_write && !push;
    ser_last   = busy_q && (nib_cnt_q == NIB_LAST);
    pop        = (!busy_q || ser_last) && (occ_q != {OCC_W{1'b0}});
    ser_idle   = !busy_q && !data_valid_q && (occ_q == {OCC_W{1'b0}});
    drain_exit = (state_q == S_DRAIN) && ser_idle;
    last_run   = (run_cnt_q == RC_LAST);
    done_err   = kern_done && (state_q != S_WAIT);
    cnt_err    = drain_exit && (word_cnt_q != WC_EXP);
    err_set    = drop || done_err || cnt_err;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end else begin
      occ_d = occ_q;
    end
  end

  // FIFO storage; emptiness is governed by the pointers, so no reset needed
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= y_out_din;
    end
  end

  // FIFO pointers, occupancy and the registered not-full flag
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
      full_n_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q    <= occ_d;
      full_n_q <= (occ_d != OCC_FULL);
    end
  end

  // Nibble serializer: reloads on its last nibble so back-to-back words stay gapless
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sh_q         <= {DATA_W{1'b0}};
      nib_cnt_q    <= {NC_W{1'b0}};
      busy_q       <= 1'b0;
      data_out_q   <= {NIB_W{1'b0}};
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= busy_q ? sh_q[NIB_W-1:0] : {NIB_W{1'b0}};
      data_valid_q <= busy_q;
      if (pop) begin
        sh_q      <= mem_q[rd_ptr_q];
        nib_cnt_q <= {NC_W{1'b0}};
        busy_q    <= 1'b1;
      end else if (busy_q) begin
        sh_q      <= sh_q >> NIB_W;
        nib_cnt_q <= nib_cnt_q + NC_W'(1);
        busy_q    <= !ser_last;
      end else begin
        busy_q    <= 1'b0;
      end
    end
  end

  // Run-control FSM with its counters, sticky error and registered outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= S_IDLE;
      kern_start_q <= 1'b0;
      probe_q      <= 1'b0;
      err_q        <= 1'b0;
      word_cnt_q   <= {WC_W{1'b0}};
      run_cnt_q    <= {RC_W{1'b0}};
    end else begin
      err_q   <= err_q || err_set;
      probe_q <= ((state_q == S_FINISH) || (drain_exit && last_run)) && !err_q && !err_set;
      // A word arriving on the DRAIN-exit edge belongs to the next run
      if (drain_exit) begin
        word_cnt_q <= push ? WC_W'(1) : {WC_W{1'b0}};
      end else if (push && (word_cnt_q != WC_MAX)) begin
        word_cnt_q <= word_cnt_q + WC_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          state_q      <= S_START;
          kern_start_q <= 1'b1;
        end
        S_START: begin
          if (kern_ready) begin
            state_q      <= S_WAIT;
            kern_start_q <= 1'b0;
          end else begin
            kern_start_q <= 1'b1;
          end
        end
        S_WAIT: begin
          kern_start_q <= 1'b0;
          if (kern_done) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (ser_idle) begin
            run_cnt_q    <= run_cnt_q + RC_W'(1);
            state_q      <= last_run ? S_FINISH : S_START;
            kern_start_q <= !last_run;
          end
        end
        S_FINISH: begin
          kern_start_q <= 1'b0;
        end
        default: begin
          state_q      <= S_IDLE;
          kern_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign kern_start   = kern_start_q;
  assign y_out_full_n = full_n_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign probe_out    = probe_q;

endmodule

// File: tb/tb_atax_run_sequencer.sv
// Self-checking bench: a kernel model drives sessions, a monitor collects the nibble
// stream, and expectations come from the list of words the kernel model handed over.
module tb_atax_run_sequencer;

  localparam int DATA_W     = 32;
  localparam int NIB_W      = 4;
  localparam int N_OUT      = 16;
  localparam int NUM_RUNS   = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int NIBS       = DATA_W / NIB_W;

  localparam int M_NOM   = 0;
  localparam int M_RND   = 1;
  localparam int M_OVF   = 2;
  localparam int M_SHORT = 3;
  localparam int M_LAT   = 4;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              kern_start;
  logic              kern_ready;
  logic              kern_done;
  logic              y_out_write;
  logic [DATA_W-1:0] y_out_din;
  logic              y_out_full_n;
  logic [NIB_W-1:0]  data_out;
  logic              data_valid;
  logic              probe_out;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] nib_q[$];
  int         start_cnt = 0;
  logic       ks_prev = 1'b0;

  atax_run_sequencer #(
    .DATA_W(DATA_W), .NIB_W(NIB_W), .N_OUT(N_OUT),
    .NUM_RUNS(NUM_RUNS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .kern_start(kern_start), .kern_ready(kern_ready), .kern_done(kern_done),
    .y_out_write(y_out_write), .y_out_din(y_out_din), .y_out_full_n(y_out_full_n),
    .data_out(data_out), .data_valid(data_valid), .probe_out(probe_out)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Monitor: record every valid nibble and every rising edge of kern_start
  always @(negedge ap_clk) begin
    if (data_valid === 1'b1) nib_q.push_back(data_out);
    if (kern_start === 1'b1 && ks_prev !== 1'b1) start_cnt++;
    ks_prev = kern_start;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge ap_clk);
  endtask

  task automatic apply_reset();
    ap_rst_n = 1'b0;
    repeat (3) cyc();
    ap_rst_n = 1'b1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (kern_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  // Write one word now and check the exact nibble timing on the following cycles
  task automatic latency_probe(input logic [31:0] w, input int n_samples, input string tag);
    logic exp_dv;
    y_out_write = 1'b1;
    y_out_din   = w;
    for (int j = 1; j <= n_samples; j++) begin
      cyc();
      y_out_write = 1'b0;
      exp_dv = (j >= 3) && (j <= 2 + NIBS);
      check_eq($sformatf("%s_dv%0d", tag, j), {31'd0, data_valid}, {31'd0, exp_dv});
      if (exp_dv) check_eq($sformatf("%s_nib%0d", tag, j - 3), {28'd0, data_out}, (w >> (4 * (j - 3))) & 32'hF);
    end
  endtask

  task automatic run_session(input int mode);
    logic [31:0] exp_w[$];
    logic [31:0] w;
    logic [31:0] got;
    int base_n, base_s, nwords, i, guard;
    bit ok, ovf_done, done_with_last, saw_full, exp_err;
    base_n   = nib_q.size();
    base_s   = start_cnt;
    ovf_done = 1'b0;
    saw_full = 1'b0;
    exp_err  = (mode == M_OVF) || (mode == M_SHORT);
    for (int r = 0; r < NUM_RUNS; r++) begin
      wait_start(ok);
      check_eq($sformatf("m%0d_r%0d_start_seen", mode, r), {31'd0, kern_start}, 32'd1);
      if (!ok) return;
      repeat ((mode == M_RND) ? $urandom_range(0, 4) : 2) cyc();
      kern_ready = 1'b1;
      cyc();
      kern_ready = 1'b0;
      nwords = (mode == M_SHORT && r == 2) ? N_OUT - 1 : N_OUT;
      i = 0;
      guard = 0;
      done_with_last = 1'b0;
      while (i < nwords && guard < 2000) begin
        guard++;
        if (mode == M_LAT && r == 0 && i == 0) begin
          latency_probe(32'h12345678, NIBS + 3, "lat");
          exp_w.push_back(32'h12345678);
          i++;
        end else begin
          if (y_out_full_n !== 1'b1) saw_full = 1'b1;
          if (mode == M_RND && $urandom_range(0, 3) == 0) begin
            y_out_write = 1'b0;
          end else if (y_out_full_n === 1'b1) begin
            w = (mode == M_RND) ? $urandom : 32'hA0 + i;
            y_out_write = 1'b1;
            y_out_din   = w;
            exp_w.push_back(w);
            i++;
            if (i == nwords && mode == M_RND && $urandom_range(0, 1) == 1) begin
              kern_done      = 1'b1;
              done_with_last = 1'b1;
            end
          end else if (mode == M_OVF && r == 1 && !ovf_done) begin
            y_out_write = 1'b1;
            y_out_din   = 32'hDEADBEEF;
            ovf_done    = 1'b1;
          end
          cyc();
          y_out_write = 1'b0;
          kern_done   = 1'b0;
        end
      end
      check_eq($sformatf("m%0d_r%0d_words_sent", mode, r), i, nwords);
      if (!done_with_last) begin
        kern_done = 1'b1;
        cyc();
        kern_done = 1'b0;
      end
    end
    guard = 0;
    while ((nib_q.size() - base_n) < exp_w.size() * NIBS && guard < 3000) begin
      cyc();
      guard++;
    end
    repeat (6) cyc();
    check_eq($sformatf("m%0d_nibble_count", mode), nib_q.size() - base_n, exp_w.size() * NIBS);
    for (int k = 0; k < exp_w.size(); k++) begin
      got = 32'd0;
      for (int n = 0; n < NIBS; n++) begin
        if (base_n + k * NIBS + n < nib_q.size())
          got = got | ({28'd0, nib_q[base_n + k * NIBS + n]} << (4 * n));
      end
      check_eq($sformatf("m%0d_word%0d", mode, k), got, exp_w[k]);
    end
    check_eq($sformatf("m%0d_start_count", mode), start_cnt - base_s, NUM_RUNS);
    check_eq($sformatf("m%0d_probe", mode), {31'd0, probe_out}, {31'd0, !exp_err});
    check_eq($sformatf("m%0d_kstart_final", mode), {31'd0, kern_start}, 32'd0);
    if (mode == M_NOM) check_eq("nom_backpressure_seen", {31'd0, saw_full}, 32'd1);
    if (mode == M_OVF) check_eq("ovf_injected", {31'd0, ovf_done}, 32'd1);
  endtask

  initial begin
    int  n0;
    bit  ok;
    ap_rst_n    = 1'b0;
    kern_ready  = 1'b0;
    kern_done   = 1'b0;
    y_out_write = 1'b0;
    y_out_din   = 32'd0;
    repeat (3) cyc();
    check_eq("rst_kern_start", {31'd0, kern_start}, 32'd0);
    check_eq("rst_data_out", {28'd0, data_out}, 32'd0);
    check_eq("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check_eq("rst_probe", {31'd0, probe_out}, 32'd0);
    check_eq("rst_full_n", {31'd0, y_out_full_n}, 32'd0);
    ap_rst_n = 1'b1;
    cyc();
    check_eq("full_n_after_release", {31'd0, y_out_full_n}, 32'd1);

    apply_reset();
    run_session(M_NOM);
    n0 = nib_q.size();
    y_out_write = 1'b1;
    y_out_din   = 32'h5A5A5A5A;
    cyc();
    y_out_write = 1'b0;
    repeat (12) cyc();
    check_eq("finish_write_probe", {31'd0, probe_out}, 32'd0);
    check_eq("finish_write_dropped", nib_q.size() - n0, 32'd0);

    apply_reset();
    run_session(M_LAT);
    apply_reset();
    run_session(M_RND);
    apply_reset();
    run_session(M_RND);
    apply_reset();
    run_session(M_OVF);
    apply_reset();
    run_session(M_SHORT);

    // Reset while nibble 3 of a word is on the pins
    apply_reset();
    wait_start(ok);
    check_eq("rstmid_start_seen", {31'd0, kern_start}, 32'd1);
    repeat (2) cyc();
    kern_ready = 1'b1;
    cyc();
    kern_ready = 1'b0;
    latency_probe(32'h12345678, 6, "rstmid");
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_eq("rstmid_data_valid", {31'd0, data_valid}, 32'd0);
    check_eq("rstmid_data_out", {28'd0, data_out}, 32'd0);
    check_eq("rstmid_kern_start", {31'd0, kern_start}, 32'd0);
    check_eq("rstmid_full_n", {31'd0, y_out_full_n}, 32'd0);
    check_eq("rstmid_probe", {31'd0, probe_out}, 32'd0);
    repeat (3) cyc();
    ap_rst_n = 1'b1;
    run_session(M_NOM);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
